// File: rtl/nqcpu_pkg.sv
// nqcpu_pkg: state encoding, bus lane constants and widths shared by nqcpu pipeline stages
package nqcpu_pkg;
  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, DONE} state_t;
  localparam logic [1:0] BE_LO = 2'b01;
  localparam logic [1:0] BE_HI = 2'b10;
  localparam logic [1:0] BE_W = 2'b11;
  localparam logic [15:0] ERR_DATA_DEF = 16'hDEAD;
  localparam int CTRL_W = 33;
endpackage

// File: rtl/mem_lane_mux.sv
// mem_lane_mux: byte-lane steering for store data and load-result assembly
module mem_lane_mux
  import nqcpu_pkg::*;
(
  input  logic        i_word,
  input  logic        i_odd,
  input  logic        i_beat2,
  input  logic [15:0] i_wdata,
  input  logic [15:0] i_rdata,
  input  logic [15:0] i_acc,
  output logic [1:0]  o_be1,
  output logic [15:0] o_wdata1,
  output logic [15:0] o_wdata2,
  output logic [15:0] o_result
);
  logic w_aligned_word;
  assign w_aligned_word = i_word && !i_odd;
  assign o_be1 = w_aligned_word ? BE_W : i_odd ? BE_HI : BE_LO;
  assign o_wdata1 = w_aligned_word ? i_wdata : {2{i_wdata[7:0]}};
  assign o_wdata2 = {2{i_wdata[15:8]}};
  // a misaligned first beat lands in the low result byte just like an odd byte load
  assign o_result = i_beat2 ? {i_rdata[7:0], i_acc[7:0]} :
                    w_aligned_word ? i_rdata :
                    {8'h00, i_odd ? i_rdata[15:8] : i_rdata[7:0]};
endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store stage driving a 16-bit byte-enabled req/ack bus,
// splitting misaligned words into two beats with a per-beat ack timeout.
module mem_stage
  import nqcpu_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [15:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [15:0]       addr_in,
  input  logic [15:0]       wdata_in,
  input  logic              rd_b,
  input  logic              rd_w,
  input  logic              wr_b,
  input  logic              wr_w,
  input  logic [15:0]       pc_in,
  input  logic [15:0]       imm_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              bus_req,
  output logic              bus_we,
  output logic [14:0]       bus_addr,
  output logic [1:0]        bus_be,
  output logic [15:0]       bus_wdata,
  input  logic [15:0]       bus_rdata,
  input  logic              bus_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       rdata_out,
  output logic [15:0]       pc_out,
  output logic [15:0]       imm_out,
  output logic [CTRL_W-1:0] ctrl_out
);
  localparam logic [15:0] TO_LAST = 16'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  state_t r_state, w_next;
  logic r_word, r_odd, r_load;
  logic [15:0] r_wdata, r_acc, r_cnt;
  logic w_rd, w_wr, w_none, w_ill, w_word, w_ack, w_to, w_two, w_idle;
  logic [1:0] w_be1;
  logic [15:0] w_wdata1, w_wdata2, w_result;
  assign w_rd = rd_b | rd_w;
  assign w_wr = wr_b | wr_w;
  assign w_none = !w_rd && !w_wr;
  assign w_ill = w_rd && w_wr;
  assign w_word = w_rd ? rd_w : wr_w;
  assign w_idle = r_state == IDLE;
  assign w_ack = bus_req && bus_ack;
  assign w_to = (TIMEOUT != 0) && bus_req && !bus_ack && r_cnt == TO_LAST;
  assign w_two = r_word && r_odd;
  mem_lane_mux u_mux (
    .i_word  (w_idle ? w_word : r_word),
    .i_odd   (w_idle ? addr_in[0] : r_odd),
    .i_beat2 (r_state == BEAT2),
    .i_wdata (w_idle ? wdata_in : r_wdata),
    .i_rdata (bus_rdata),
    .i_acc   (r_acc),
    .o_be1   (w_be1),
    .o_wdata1(w_wdata1),
    .o_wdata2(w_wdata2),
    .o_result(w_result)
  );
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !en ? IDLE : (w_none || w_ill) ? DONE : BEAT1;
      BEAT1:   w_next = w_ack ? (w_two ? BEAT2 : DONE) : w_to ? DONE : BEAT1;
      BEAT2:   w_next = (w_ack || w_to) ? DONE : BEAT2;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    busy = r_state != IDLE;
    done = r_state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
      err <= 1'b0;
      rdata_out <= '0;
      pc_out <= '0;
      imm_out <= '0;
      ctrl_out <= '0;
      r_word <= 1'b0;
      r_odd <= 1'b0;
      r_load <= 1'b0;
      r_wdata <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      bus_req <= w_next == BEAT1 || w_next == BEAT2;
      r_cnt <= (bus_req && w_next == r_state) ? r_cnt + 16'd1 : 16'd0;
      if (w_idle && en) begin
        r_word <= w_word;
        r_odd <= addr_in[0];
        r_load <= w_rd;
        r_wdata <= wdata_in;
        bus_we <= w_wr;
        bus_addr <= addr_in[15:1];
        bus_be <= w_be1;
        bus_wdata <= w_wdata1;
        err <= w_ill;
        pc_out <= pc_in;
        imm_out <= imm_in;
        ctrl_out <= ctrl_in;
      end
      // second beat of a misaligned word: next word address, wrapping at the top
      if (r_state == BEAT1 && w_ack && w_two) begin
        r_acc <= w_result;
        bus_addr <= bus_addr + 15'd1;
        bus_be <= BE_LO;
        bus_wdata <= w_wdata2;
      end
      if (w_ack && w_next == DONE && r_load) rdata_out <= w_result;
      if (w_to) begin
        err <= 1'b1;
        if (r_load) rdata_out <= ERR_DATA;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: random and directed load/store traffic against a byte-memory reference model
module tb_mem_stage;
  import nqcpu_pkg::*;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [15:0] addr_in = '0, wdata_in = '0, pc_in = '0, imm_in = '0, bus_rdata = '0;
  logic rd_b = 1'b0, rd_w = 1'b0, wr_b = 1'b0, wr_w = 1'b0, bus_ack = 1'b0;
  logic [32:0] ctrl_in = '0;
  logic bus_req, bus_we, busy, done, err;
  logic [14:0] bus_addr;
  logic [1:0] bus_be;
  logic [15:0] bus_wdata, rdata_out, pc_out, imm_out;
  logic [32:0] ctrl_out;
  int n_tests = 0, n_fail = 0;
  logic [7:0] rmem [65536];
  logic [15:0] smem [32768];
  logic [15:0] exp_rd = '0;
  always #5 clk = ~clk;
  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .en(en), .addr_in(addr_in), .wdata_in(wdata_in),
    .rd_b(rd_b), .rd_w(rd_w), .wr_b(wr_b), .wr_w(wr_w),
    .pc_in(pc_in), .imm_in(imm_in), .ctrl_in(ctrl_in),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .busy(busy), .done(done), .err(err), .rdata_out(rdata_out),
    .pc_out(pc_out), .imm_out(imm_out), .ctrl_out(ctrl_out)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_byte(input logic [15:0] a, input logic [7:0] v);
    rmem[a] = v;
    if (a[0]) smem[a[15:1]][15:8] = v;
    else smem[a[15:1]][7:0] = v;
  endtask
  // fl = {rd_b, rd_w, wr_b, wr_w}; mw = max ack wait per beat; nack = slave never acks
  task automatic do_op(input logic [3:0] fl, input logic [15:0] a, input logic [15:0] wd,
                       input int mw, input bit nack);
    logic [15:0] pc, im, ba[2];
    logic [32:0] ct;
    logic [7:0] bv[2];
    logic [14:0] eaddr[2];
    logic [1:0] ebe[2], ln;
    logic rd, wr, word, mem_op, got;
    int nb, nbeats, lat, waits, bi, reqs, total, exp_lat;
    bit newb;
    rd = fl[3] | fl[2];
    wr = fl[1] | fl[0];
    word = rd ? fl[2] : fl[0];
    mem_op = (rd || wr) && !(rd && wr);
    nb = word ? 2 : 1;
    ba[0] = a;
    ba[1] = a + 16'd1;
    bv[0] = wd[7:0];
    bv[1] = wd[15:8];
    nbeats = 0;
    for (int i = 0; i < nb; i++) begin
      ln = ba[i][0] ? 2'b10 : 2'b01;
      if (nbeats > 0 && eaddr[nbeats-1] == ba[i][15:1]) ebe[nbeats-1] |= ln;
      else begin
        eaddr[nbeats] = ba[i][15:1];
        ebe[nbeats] = ln;
        nbeats++;
      end
    end
    pc = 16'($urandom);
    im = 16'($urandom);
    ct = {1'($urandom), 32'($urandom)};
    @(negedge clk);
    {rd_b, rd_w, wr_b, wr_w} = fl;
    addr_in = a;
    wdata_in = wd;
    pc_in = pc;
    imm_in = im;
    ctrl_in = ct;
    en = 1'b1;
    lat = 0; bi = 0; reqs = 0; total = 0; newb = 1; got = 0;
    waits = nack ? 0 : $urandom_range(0, mw);
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      bus_ack = 1'b0;
      bus_rdata = 16'($urandom);
      addr_in = 16'($urandom);
      wdata_in = 16'($urandom);
      pc_in = 16'($urandom);
      {rd_b, rd_w, wr_b, wr_w} = 4'($urandom);
      if (done) begin
        got = 1;
        en = 1'b0;
      end else begin
        en = 1'($urandom);
        if (bus_req) begin
          reqs++;
          if (newb) begin
            if (bi < nbeats) begin
              check("beat_addr", bus_addr, eaddr[bi]);
              check("beat_be", bus_be, ebe[bi]);
              check("beat_we", bus_we, wr);
              if (wr) for (int i = 0; i < nb; i++)
                if (ba[i][15:1] == eaddr[bi])
                  check("beat_lane", ba[i][0] ? bus_wdata[15:8] : bus_wdata[7:0], bv[i]);
              if (wr && !word) check("byte_wdata_dup", bus_wdata, {2{wd[7:0]}});
            end else check("extra_beat", 1, 0);
            newb = 0;
          end
          if (!nack && waits == 0) begin
            bus_ack = 1'b1;
            bus_rdata = smem[bus_addr];
            if (bus_we && bus_be[0]) smem[bus_addr][7:0] = bus_wdata[7:0];
            if (bus_we && bus_be[1]) smem[bus_addr][15:8] = bus_wdata[15:8];
            bi++;
            newb = 1;
            waits = $urandom_range(0, mw);
          end else begin
            waits--;
            total++;
          end
        end
      end
    end
    en = 1'b0;
    {rd_b, rd_w, wr_b, wr_w} = 4'b0;
    check("done_seen", got, 1);
    exp_lat = !mem_op ? 1 : nack ? 5 : 1 + nbeats + total;
    check("latency", lat, exp_lat);
    if (mem_op && nack) check("timeout_req_cycles", reqs, 4);
    else if (mem_op) check("beats", bi, nbeats);
    else check("no_bus", reqs, 0);
    check("err", err, (rd && wr) || (mem_op && nack));
    if (mem_op && rd) exp_rd = nack ? 16'hDEAD : word ? {rmem[ba[1]], rmem[ba[0]]} : {8'h00, rmem[a]};
    if (mem_op && wr && !nack) for (int i = 0; i < nb; i++) rmem[ba[i]] = bv[i];
    check("rdata_out", rdata_out, exp_rd);
    check("pc_out", pc_out, pc);
    check("imm_out", imm_out, im);
    check("ctrl_out", ctrl_out, ct);
    @(negedge clk);
    check("done_one_cycle", {done, busy}, 2'b00);
  endtask
  initial begin
    logic [3:0] kinds [6];
    logic [3:0] fl;
    logic [15:0] a;
    kinds = '{4'b0100, 4'b1000, 4'b0010, 4'b0001, 4'b1100, 4'b0011};
    for (int w = 0; w < 32768; w++) begin
      smem[w] = 16'($urandom);
      rmem[2*w] = smem[w][7:0];
      rmem[2*w+1] = smem[w][15:8];
    end
    repeat (3) @(negedge clk);
    check("rst_outs", {bus_req, bus_we, busy, done, err}, 5'b0);
    check("rst_bus", {bus_addr, bus_be, bus_wdata}, 33'b0);
    check("rst_data", {rdata_out, pc_out, imm_out}, 48'b0);
    check("rst_ctrl", ctrl_out, 33'b0);
    rst = 1'b0;
    set_byte(16'h1234, 8'hEF);
    set_byte(16'h1235, 8'hBE);
    do_op(4'b0100, 16'h1234, 16'h0, 0, 0);
    check("word_load_beef", rdata_out, 16'hBEEF);
    do_op(4'b0010, 16'h0011, 16'h00A5, 0, 0);
    check("byte_store_keeps_rdata", rdata_out, 16'hBEEF);
    set_byte(16'hFFFF, 8'h34);
    set_byte(16'h0000, 8'h12);
    do_op(4'b0100, 16'hFFFF, 16'h0, 0, 0);
    check("misaligned_wrap_load", rdata_out, 16'h1234);
    do_op(4'b0100, 16'h2000, 16'h0, 0, 1);
    check("timeout_err_data", rdata_out, 16'hDEAD);
    do_op(4'b0110, 16'h0100, 16'h5555, 0, 0);
    do_op(4'b0000, 16'h0102, 16'h0, 0, 0);
    @(negedge clk);
    rd_w = 1'b1;
    addr_in = 16'h0040;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    rd_w = 1'b0;
    check("rst_mid_req_up", bus_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_idle", {bus_req, busy, done}, 3'b000);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check("late_ack_ignored", {bus_req, busy, done}, 3'b000);
    exp_rd = '0;
    check("rst_mid_rdata", rdata_out, 16'h0);
    do_op(4'b1000, 16'h0041, 16'h0, 2, 0);
    for (int n = 0; n < 300; n++) begin
      fl = ($urandom_range(0, 9) == 0) ? 4'($urandom) : kinds[$urandom_range(0, 5)];
      a = $urandom_range(0, 1) ? 16'($urandom_range(0, 63)) : 16'($urandom_range(16'hFFC0, 16'hFFFF));
      do_op(fl, a, 16'($urandom), 3, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of alu_stage; replaces the constant memData_in tie-off with real load/store traffic.
- Accepts one operation per en pulse: address, store data and byte/word read/write flags from the ALU stage.
- Runs a req/ack transaction on a 16-bit byte-enabled bus and returns load data with a one-cycle done pulse to the control unit.
- Passes pc/imm/control bundle through with the result so downstream writeback sees a coherent packet.

Parameters:
- TIMEOUT, 255, max cycles a beat waits for bus_ack before abort; 0 disables the timeout.
- ERR_DATA, 16'hDEAD, load result returned on any error.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous active-high reset.
- en  in  1  accept one operation (sampled only in IDLE).
- addr_in  in  16  byte address.
- wdata_in  in  16  store data.
- rd_b / rd_w / wr_b / wr_w  in  1 each  byte read, word read, byte write, word write.
- pc_in  in  16  pc pass-through.
- imm_in  in  16  imm pass-through.
- ctrl_in  in  33  control bundle pass-through.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  15  word address (byte address bits 15:1).
- bus_be  out  2  byte lanes; bit0 = [7:0] = even byte, bit1 = [15:8].
- bus_wdata  out  16  write data.
- bus_rdata  in  16  read data, valid with bus_ack.
- bus_ack  in  1  beat completion.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done.
- rdata_out  out  16  load result, valid with done, held until next done.
- pc_out / imm_out / ctrl_out  out  16/16/33  registered at accept.

Behaviour:
- Reset: state IDLE; bus_req, bus_we, busy, done and err = 0; bus_addr, bus_be, bus_wdata, rdata_out, pc_out, imm_out and ctrl_out = 0.
- States: IDLE, BEAT1, BEAT2, DONE.
- IDLE + en: latch all inputs. Decode the operation:
  - No flag set: go to DONE, no bus activity.
  - Any read flag and any write flag together: go to DONE with err=1, no bus activity.
  - rd_w with rd_b: treated as word read. wr_w with wr_b: treated as word write.
  - Otherwise go to BEAT1.
- en while busy is ignored.
- Bus rule: bus_req is registered and asserted from the first cycle in BEAT1/BEAT2. A beat completes on the posedge where bus_req=1 and bus_ack=1. bus_req drops the cycle after completion unless BEAT2 follows.
- Little-endian; byte loads zero-extend to {8'h00, byte}.
- Byte access:
  - Even address: be=01, load takes lane [7:0].
  - Odd address: be=10, load takes lane [15:8].
  - Byte stores drive {wdata[7:0], wdata[7:0]}.
- Aligned word (addr[0]=0): single beat, be=11.
- Misaligned word (addr[0]=1): two beats.
  - BEAT1: word address addr[15:1], be=10; carries low byte (store: wdata[7:0] on lane [15:8]; load: lane [15:8] to result[7:0]).
  - BEAT2: word address addr[15:1]+1, wrapping 0x7FFF to 0x0000, be=01; carries high byte (store: wdata[15:8] on lane [7:0]; load: lane [7:0] to result[15:8]).
- DONE: done=1 for exactly one cycle, then IDLE. Loads update rdata_out; stores leave it unchanged.
- Latency, en to done:
  - Non-memory or illegal op: 1 cycle.
  - Aligned access with immediate ack: 2 cycles.
  - Misaligned access with immediate acks: 3 cycles.
  - Each cycle of ack wait adds 1.
- Timeout: a per-beat counter is cleared when the beat starts. If it reaches TIMEOUT without ack, abort: drop bus_req, go to DONE with err=1. Loads then return ERR_DATA. For a misaligned store, a completed BEAT1 write is not undone.
- bus_ack outside an active req is ignored.
- Reset mid-transaction: bus_req low after that edge and state IDLE; the bus slave must tolerate abandoned requests.

Decomposition:
- Shared package nqcpu_pkg:
  - state enum.
  - bus_be lane constants BE_LO=2'b01, BE_HI=2'b10, BE_W=2'b11.
  - ERR_DATA default.
  - ctrl bundle width (33).
- One natural sub-module, mem_lane_mux: combinational lane steering for store data and load-byte assembly. The FSM and timeout stay in mem_stage.

Test Plan:
- Word load at 0x1234, bus_rdata=0xBEEF, ack in the first req cycle:
  - bus_addr=0x091A, be=11, we=0.
  - done 2 cycles after en; rdata_out=0xBEEF, err=0.
- Byte store 0x00A5 to 0x0011:
  - be=10, bus_wdata=0xA5A5, we=1, one beat.
  - done after ack; rdata_out unchanged.
- Misaligned word load at 0xFFFF, beat1 rdata=0x34xx, beat2 rdata=0xxx12:
  - beat1 bus_addr=0x7FFF be=10; beat2 bus_addr=0x0000 be=01.
  - rdata_out=0x1234; done 3 cycles after en.
- TIMEOUT=4, word load with ack never asserted:
  - bus_req high for 4 cycles then low.
  - done with err=1, rdata_out=0xDEAD.
- Illegal and empty ops:
  - en with rd_w=1 and wr_b=1: no bus_req; done next cycle with err=1.
  - en with no flags: done next cycle, err=0, pc_out=pc_in.
- rst asserted while waiting for ack in BEAT1:
  - bus_req=0 and busy=0 next cycle, no done.
  - A late bus_ack is ignored; the next en is accepted normally.
